// File: rtl/mult2x2_selftest_if.sv
// mult2x2_selftest_if: control, operand and verdict bundle between the self-test sequencer and its user.
interface mult2x2_selftest_if;
    logic       start;
    logic       abort;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] fail_idx;
    logic [3:0] fail_y;
    modport master (
        output start, abort, y,
        input  a, b, busy, done, pass, err_count, fail_valid, fail_idx, fail_y
    );
    modport slave (
        input  start, abort, y,
        output a, b, busy, done, pass, err_count, fail_valid, fail_idx, fail_y
    );
endinterface

// File: rtl/mult2x2_selftest.sv
// mult2x2_selftest: walks all 16 operand pairs through a 2x2 multiplier and records a verdict.
module mult2x2_selftest #(
    parameter int unsigned SETTLE = 2
) (
    input logic               clk,
    input logic               rst_n,
    mult2x2_selftest_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_DRIVE = 2'd1, S_CHECK = 2'd2, S_DONE = 2'd3;
    logic [1:0] r_state;
    logic [3:0] r_idx, r_cnt, r_ys, r_fail_idx, r_fail_y;
    logic [4:0] r_err;
    logic       r_fail_valid;
    logic [3:0] w_exp;
    logic       w_go, w_run, w_mis;
    assign w_exp = {2'b00, r_idx[3:2]} * {2'b00, r_idx[1:0]};
    assign w_mis = r_ys != w_exp;
    assign w_run = r_state == S_DRIVE || r_state == S_CHECK;
    assign w_go  = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    // y is captured on the DRIVE->CHECK edge; CHECK then judges that captured value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 4'd0;
            r_cnt        <= 4'd0;
            r_ys         <= 4'd0;
            r_err        <= 5'd0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= 4'd0;
            r_fail_y     <= 4'd0;
        end else if (w_go) begin
            r_state      <= S_DRIVE;
            r_idx        <= 4'd0;
            r_cnt        <= 4'(SETTLE);
            r_err        <= 5'd0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= 4'd0;
            r_fail_y     <= 4'd0;
        end else if (w_run && bus.abort) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
        end else if (r_state == S_DRIVE) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                r_state <= S_CHECK;
                r_ys    <= bus.y;
            end
        end else if (r_state == S_CHECK) begin
            if (w_mis) begin
                r_err <= r_err + 5'd1;
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_idx   <= r_idx;
                    r_fail_y     <= r_ys;
                end
            end
            if (r_idx == 4'd15) begin
                r_state <= S_DONE;
            end else begin
                r_idx   <= r_idx + 4'd1;
                r_cnt   <= 4'(SETTLE);
                r_state <= S_DRIVE;
            end
        end
    end
    assign bus.a          = r_idx[3:2];
    assign bus.b          = r_idx[1:0];
    assign bus.busy       = w_run;
    assign bus.done       = r_state == S_DONE;
    assign bus.pass       = r_state == S_DONE && r_err == 5'd0;
    assign bus.err_count  = r_err;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_idx   = r_fail_idx;
    assign bus.fail_y     = r_fail_y;
endmodule

// File: tb/tb_mult2x2_selftest.sv
// tb_mult2x2_selftest: directed checks of the multiplier self-test sequencer at SETTLE = 1, 2 and 3.
module tb_mult2x2_selftest;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fault = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [3:0] l1a, l1b, l3a, l3b;
    mult2x2_selftest_if if1 ();
    mult2x2_selftest_if if2 ();
    mult2x2_selftest_if if3 ();
    mult2x2_selftest #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mult2x2_selftest #(.SETTLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mult2x2_selftest #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    always #5 clk = ~clk;
    // dut2 sees a combinational multiplier with optional y[0] stuck at 0; dut1/dut3 see a 2-cycle-late one
    assign if2.y = ({2'b00, if2.a} * {2'b00, if2.b}) & {3'b111, ~fault};
    always_ff @(posedge clk) begin
        l1a <= {2'b00, if1.a} * {2'b00, if1.b};
        l1b <= l1a;
        l3a <= {2'b00, if3.a} * {2'b00, if3.b};
        l3b <= l3a;
    end
    assign if1.y = l1b;
    assign if3.y = l3b;

    task tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task start2;
        if2.start = 1'b1;
        tick;
        if2.start = 1'b0;
        cyc = 0;
    endtask

    task wait_done(input int sel);
        while (!(sel == 1 ? if1.done : sel == 3 ? if3.done : if2.done) && cyc < 200) tick;
    endtask

    task test_reset;
        n_chk++;
        if ({if2.a, if2.b, if2.busy, if2.done, if2.pass, if2.fail_valid} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {if2.a, if2.b, if2.busy, if2.done, if2.pass, if2.fail_valid});
        end
        n_chk++;
        if ({if2.err_count, if2.fail_idx, if2.fail_y} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_verdict: got %h expected 0", {if2.err_count, if2.fail_idx, if2.fail_y});
        end
        n_chk++;
        if ({if1.busy, if1.done, if3.busy, if3.done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_other: got %b expected 0000", {if1.busy, if1.done, if3.busy, if3.done});
        end
    endtask

    task test_clean_run;
        fault = 1'b0;
        start2;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 3; c++) begin
                n_chk++;
                if ({if2.a, if2.b, if2.busy, if2.done} !== {4'(k), 2'b10}) begin
                    n_fail++;
                    $display("FAIL walk k=%0d c=%0d: got %b expected %b", k, c, {if2.a, if2.b, if2.busy, if2.done}, {4'(k), 2'b10});
                end
                tick;
            end
        end
        n_chk++;
        if ({if2.busy, if2.done, if2.pass, if2.fail_valid, if2.err_count} !== {4'b0110, 5'd0}) begin
            n_fail++;
            $display("FAIL clean_verdict: got %b expected 011000000", {if2.busy, if2.done, if2.pass, if2.fail_valid, if2.err_count});
        end
        n_chk++;
        if ({if2.a, if2.b} !== 4'hF) begin
            n_fail++;
            $display("FAIL done_hold_ab: got %h expected f", {if2.a, if2.b});
        end
    endtask

    task test_stuck;
        fault = 1'b1;
        start2;
        wait_done(2);
        n_chk++;
        if (cyc !== 48) begin
            n_fail++;
            $display("FAIL stuck_latency: got %0d expected 48", cyc);
        end
        n_chk++;
        if ({if2.done, if2.pass, if2.fail_valid, if2.err_count} !== {3'b101, 5'd4}) begin
            n_fail++;
            $display("FAIL stuck_verdict: got %b expected 10100100", {if2.done, if2.pass, if2.fail_valid, if2.err_count});
        end
        n_chk++;
        if ({if2.fail_idx, if2.fail_y} !== 8'h50) begin
            n_fail++;
            $display("FAIL stuck_first: got %h expected 50", {if2.fail_idx, if2.fail_y});
        end
    endtask

    task test_restart_ignore;
        fault = 1'b0;
        start2;
        n_chk++;
        if ({if2.busy, if2.done, if2.pass, if2.fail_valid, if2.err_count, if2.fail_idx, if2.fail_y} !== 17'h10000) begin
            n_fail++;
            $display("FAIL restart_clear: got %h expected 10000", {if2.busy, if2.done, if2.pass, if2.fail_valid, if2.err_count, if2.fail_idx, if2.fail_y});
        end
        repeat (9) tick;
        if2.start = 1'b1;
        tick;
        if2.start = 1'b0;
        n_chk++;
        if ({if2.busy, if2.a, if2.b} !== 5'b10011) begin
            n_fail++;
            $display("FAIL busy_start_ignored: got %b expected 10011", {if2.busy, if2.a, if2.b});
        end
        wait_done(2);
        n_chk++;
        if (cyc !== 48 || if2.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_run: got cyc=%0d pass=%b expected cyc=48 pass=1", cyc, if2.pass);
        end
    endtask

    task test_abort;
        fault = 1'b1;
        start2;
        repeat (19) tick;
        if2.abort = 1'b1;
        tick;
        if2.abort = 1'b0;
        n_chk++;
        if ({if2.a, if2.b, if2.busy, if2.done, if2.pass} !== 7'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got %b expected 0000000", {if2.a, if2.b, if2.busy, if2.done, if2.pass});
        end
        n_chk++;
        if ({if2.err_count, if2.fail_valid, if2.fail_idx, if2.fail_y} !== {5'd1, 1'b1, 8'h50}) begin
            n_fail++;
            $display("FAIL abort_partial: got %h expected 350", {if2.err_count, if2.fail_valid, if2.fail_idx, if2.fail_y});
        end
        if2.start = 1'b1;
        if2.abort = 1'b1;
        tick;
        if2.start = 1'b0;
        if2.abort = 1'b0;
        cyc = 0;
        n_chk++;
        if ({if2.busy, if2.err_count} !== {1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL start_beats_abort: got %b expected 100000", {if2.busy, if2.err_count});
        end
        repeat (23) tick;
        if2.abort = 1'b1;
        tick;
        if2.abort = 1'b0;
        n_chk++;
        if ({if2.busy, if2.err_count, if2.fail_idx} !== {1'b0, 5'd1, 4'd5}) begin
            n_fail++;
            $display("FAIL abort_in_check: got %b expected 0000010101", {if2.busy, if2.err_count, if2.fail_idx});
        end
        fault = 1'b0;
        start2;
        wait_done(2);
        n_chk++;
        if (cyc !== 48 || {if2.pass, if2.err_count} !== {1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL after_abort_run: got cyc=%0d pass=%b err=%0d expected 48 1 0", cyc, if2.pass, if2.err_count);
        end
    endtask

    task test_async_reset;
        fault = 1'b1;
        start2;
        repeat (20) tick;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({if2.a, if2.b, if2.busy, if2.done, if2.pass, if2.fail_valid, if2.err_count, if2.fail_idx, if2.fail_y} !== 21'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", {if2.a, if2.b, if2.busy, if2.done, if2.pass, if2.fail_valid, if2.err_count, if2.fail_idx, if2.fail_y});
        end
        #2 rst_n = 1'b1;
        tick;
        fault = 1'b0;
        start2;
        wait_done(2);
        n_chk++;
        if (cyc !== 48 || if2.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_run: got cyc=%0d pass=%b expected 48 1", cyc, if2.pass);
        end
    endtask

    task test_settle;
        if1.start = 1'b1;
        tick;
        if1.start = 1'b0;
        cyc = 0;
        wait_done(1);
        n_chk++;
        if (cyc !== 32 || {if1.pass, if1.fail_valid, if1.err_count} !== {2'b01, 5'd11}) begin
            n_fail++;
            $display("FAIL settle1_lag: got cyc=%0d pass=%b err=%0d expected 32 0 11", cyc, if1.pass, if1.err_count);
        end
        n_chk++;
        if ({if1.fail_idx, if1.fail_y} !== 8'h50) begin
            n_fail++;
            $display("FAIL settle1_first: got %h expected 50", {if1.fail_idx, if1.fail_y});
        end
        if3.start = 1'b1;
        tick;
        if3.start = 1'b0;
        cyc = 0;
        wait_done(3);
        n_chk++;
        if (cyc !== 64 || {if3.pass, if3.fail_valid, if3.err_count} !== {2'b10, 5'd0}) begin
            n_fail++;
            $display("FAIL settle3_lag: got cyc=%0d pass=%b err=%0d expected 64 1 0", cyc, if3.pass, if3.err_count);
        end
    endtask

    initial begin
        {if1.start, if1.abort, if2.start, if2.abort, if3.start, if3.abort} = 6'b0;
        repeat (3) tick;
        test_reset;
        #2 rst_n = 1'b1;
        tick;
        test_clean_run;
        test_stuck;
        test_restart_ignore;
        test_abort;
        test_async_reset;
        test_settle;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
